// File: rtl/multi_adder_sched.sv
// multi_adder_sched: shares one combinational multi_adder among NUM_REQ
// requesters. A round-robin arbiter grants one requester at a time. The
// granted operands are buffered and summed once. The registered sum is
// returned with the owning requester id on a valid/ready result port.
//
// Optional build macro MULTI_ADDER_SCHED_STATS_EN adds stat_done, a per-requester
// count of accepted results.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no transaction; pick next valid requester from rr_ptr
// S_LOAD | stream operands of the granted requester into op_buf
// S_ADD  | one cycle: register adder output, id and operand count
// S_DONE | hold result until res_ready, then advance rr_ptr

// Combinational reduction of NUM_OPS operands at exact width.
module multi_adder #(
    parameter int N       = 8,
    parameter int NUM_OPS = 6,
    parameter int SUM_W   = N + $clog2(NUM_OPS)
) (
    input  logic [NUM_OPS-1:0][N-1:0] ops,
    output logic [SUM_W-1:0]          sum
);

    // Sum all operands, zero-extended to the result width.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            sum = sum + SUM_W'(ops[i]);
        end
    end

endmodule

module multi_adder_sched #(
    parameter int N       = 8,
    parameter int NUM_OPS = 6,
    parameter int NUM_REQ = 4,
    localparam int SUM_W  = N + $clog2(NUM_OPS),
    localparam int ID_W   = $clog2(NUM_REQ),
    localparam int CNT_W  = $clog2(NUM_OPS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0][N-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [SUM_W-1:0]            res_sum,
    output logic [ID_W-1:0]             res_id,
`ifdef MULTI_ADDER_SCHED_STATS_EN
    output logic [NUM_REQ-1:0][15:0]    stat_done,
`endif
    output logic [CNT_W-1:0]            res_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ADD,
        S_DONE
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [ID_W-1:0]           rr_ptr;
    logic [ID_W-1:0]           grant;
    logic [ID_W-1:0]           pick;
    logic [ID_W-1:0]           rr_idx;
    logic                      any_valid;
    logic [NUM_OPS-1:0][N-1:0] op_buf;
    logic [CNT_W-1:0]          count;
    logic                      beat;
    logic                      beat_ends;
    logic                      res_accept;
    logic [SUM_W-1:0]          adder_sum;

    multi_adder #(
        .N       (N),
        .NUM_OPS (NUM_OPS),
        .SUM_W   (SUM_W)
    ) u_adder (
        .ops (op_buf),
        .sum (adder_sum)
    );

    // Round-robin pick: scan offsets from the top so the smallest offset
    // from rr_ptr wins.
    always_comb begin
        pick      = rr_ptr;
        rr_idx    = rr_ptr;
        any_valid = |req_valid;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            rr_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (req_valid[rr_idx]) begin
                pick = rr_idx;
            end
        end
    end

    // Handshake decode and next-state logic.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        beat       = 1'b0;
        beat_ends  = 1'b0;
        res_valid  = 1'b0;
        res_accept = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_valid) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                req_ready[grant] = 1'b1;
                beat      = req_valid[grant];
                beat_ends = req_last[grant] || (count == CNT_W'(NUM_OPS - 1));
                if (beat && beat_ends) begin
                    state_next = S_ADD;
                end
            end
            S_ADD: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                res_valid  = 1'b1;
                res_accept = res_ready;
                if (res_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant, operand buffer, result registers and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant     <= '0;
            op_buf    <= '0;
            count     <= '0;
            res_sum   <= '0;
            res_id    <= '0;
            res_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        grant  <= pick;
                        op_buf <= '0;
                        count  <= '0;
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        op_buf[count] <= req_data[grant];
                        count         <= count + CNT_W'(1);
                    end
                end
                S_ADD: begin
                    res_sum   <= adder_sum;
                    res_id    <= grant;
                    res_count <= count;
                end
                S_DONE: begin
                    if (res_accept) begin
                        rr_ptr <= ID_W'((int'(grant) + 1) % NUM_REQ);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MULTI_ADDER_SCHED_STATS_EN
    // Per-requester accepted-result counters; wrap naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_done <= '0;
        end else if (res_accept) begin
            stat_done[res_id] <= stat_done[res_id] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multi_adder_sched.sv
// Directed bench for multi_adder_sched (N=8, NUM_OPS=6, NUM_REQ=4).
module tb_multi_adder_sched;

    localparam int N       = 8;
    localparam int NUM_OPS = 6;
    localparam int NUM_REQ = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0][N-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      res_valid;
    logic                      res_ready;
    logic [10:0]               res_sum;
    logic [1:0]                res_id;
    logic [2:0]                res_count;
`ifdef MULTI_ADDER_SCHED_STATS_EN
    logic [NUM_REQ-1:0][15:0]  stat_done;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int stat_model [NUM_REQ];

    multi_adder_sched #(
        .N       (N),
        .NUM_OPS (NUM_OPS),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
`ifdef MULTI_ADDER_SCHED_STATS_EN
        .stat_done (stat_done),
`endif
        .res_count (res_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send_beat(input int r, input logic [7:0] d, input logic l);
        int waited = 0;
        req_valid[r] = 1'b1;
        req_data[r]  = d;
        req_last[r]  = l;
        while (!req_ready[r] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("beat_ready", 32'(req_ready[r]), 32'd1);
        @(negedge clk);
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
    endtask

    // Wait for a grant, check the ready mask, complete the beat, drop the valids.
    task automatic wait_grant(input string tag, input logic [3:0] mask);
        int waited = 0;
        while (req_ready == '0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check(tag, 32'(req_ready), 32'(mask));
        @(negedge clk);
        req_valid = req_valid & ~mask;
        req_last  = req_last & ~mask;
    endtask

    // Right after the last beat: result must appear exactly one cycle later.
    task automatic check_latency(input string tag);
        check({tag, "_lat0"}, 32'(res_valid), 32'd0);
        @(negedge clk);
        check({tag, "_lat1"}, 32'(res_valid), 32'd1);
    endtask

    task automatic get_result(input string tag, input int sum, input int id, input int cnt);
        int waited = 0;
        while (!res_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_sum"},   32'(res_sum),   32'(sum));
        check({tag, "_id"},    32'(res_id),    32'(id));
        check({tag, "_count"}, 32'(res_count), 32'(cnt));
        check({tag, "_noready"}, 32'(req_ready), 32'd0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        stat_model[id]++;
        check({tag, "_drop"}, 32'(res_valid), 32'd0);
`ifdef MULTI_ADDER_SCHED_STATS_EN
        check({tag, "_stat"}, 32'(stat_done[id]), 32'(stat_model[id]));
`endif
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear before any edge.
    task automatic reset_pulse(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_sum"},   32'(res_sum),   32'd0);
        check({tag, "_id"},    32'(res_id),    32'd0);
        check({tag, "_count"}, 32'(res_count), 32'd0);
        req_valid = '0;
        req_last  = '0;
        for (int i = 0; i < NUM_REQ; i++) stat_model[i] = 0;
`ifdef MULTI_ADDER_SCHED_STATS_EN
        check({tag, "_stat"}, 32'(stat_done), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        res_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) stat_model[i] = 0;
        @(negedge clk);
        reset_pulse("reset");

        // Full transaction of 6 x 0xFF from requester 0.
        for (int i = 0; i < 6; i++) send_beat(0, 8'hFF, i == 5);
        check_latency("full");
        get_result("full", 1530, 0, 6);

        // Partial transaction: unused slots must read as zero.
        send_beat(2, 8'd10, 1'b0);
        send_beat(2, 8'd20, 1'b0);
        send_beat(2, 8'd30, 1'b1);
        check_latency("part");
        get_result("part", 60, 2, 3);

        // Round robin from rr_ptr=0 with requesters 1 and 3 competing.
        reset_pulse("rst_rr");
        req_valid[1] = 1'b1; req_data[1] = 8'd5; req_last[1] = 1'b1;
        req_valid[3] = 1'b1; req_data[3] = 8'd9; req_last[3] = 1'b1;
        wait_grant("rr_first", 4'b0010);
        get_result("rr1", 5, 1, 1);
        wait_grant("rr_second", 4'b1000);
        get_result("rr3", 9, 3, 1);
        // rr_ptr must be back at 0: requester 0 beats requester 3.
        req_valid[0] = 1'b1; req_data[0] = 8'd2; req_last[0] = 1'b1;
        req_valid[3] = 1'b1; req_data[3] = 8'd4; req_last[3] = 1'b1;
        wait_grant("rr_wrap", 4'b0001);
        get_result("rr0", 2, 0, 1);
        wait_grant("rr_after", 4'b1000);
        get_result("rr3b", 4, 3, 1);

        // Seven beats without last: forced end at 6, 7th starts a new one.
        for (int i = 0; i < 6; i++) send_beat(0, 8'd1, 1'b0);
        req_valid[0] = 1'b1; req_data[0] = 8'd1; req_last[0] = 1'b1;
        check_latency("force");
        get_result("force6", 6, 0, 6);
        send_beat(0, 8'd1, 1'b1);
        get_result("force1", 1, 0, 1);

        // Result backpressure: outputs hold, no grant while DONE.
        send_beat(2, 8'd42, 1'b1);
        @(negedge clk);
        req_valid[1] = 1'b1; req_data[1] = 8'd3; req_last[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_sum",   32'(res_sum),   32'd42);
            check("hold_id",    32'(res_id),    32'd2);
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        get_result("hold", 42, 2, 1);
        wait_grant("hold_next", 4'b0010);
        get_result("after_hold", 3, 1, 1);

        // Reset in LOAD after two beats discards the partial transaction.
        send_beat(0, 8'd100, 1'b0);
        send_beat(0, 8'd200, 1'b0);
        check("load_ready", 32'(req_ready), 32'd1);
        reset_pulse("rst_load");
        send_beat(0, 8'd5, 1'b0);
        send_beat(0, 8'd7, 1'b1);
        check_latency("post");
        get_result("post", 12, 0, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
